line_tap_buffer: RTL and testbench

Parametrised multi-line video buffer that stores the previous NUM_TAPS-1 lines of a pixel stream and, for every input pixel, presents a vertical column of NUM_TAPS pixels at the same horizontal position. It is the generic replacement for single fixed-size 2048x9 line RAMs. It sits between the capture/colour-convert stage and windowed filters such as 3x3 and 5x5 convolution or Sobel. Depth, pixel width and tap count are generic, and the line length is set at run time.

---
 rtl/line_tap_pkg.sv | 29 ++
 rtl/sdpram_sync.sv | 27 ++
 rtl/line_tap_buffer.sv | 141 ++++++++++++++
 tb/tb_line_tap_buffer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/line_tap_pkg.sv
// Shared defaults and helpers for the line tap buffer.
//   DEFAULT_*  : default generics for the top level
//   clog2()    : ceiling log2, used for address and row counter widths
//   tap_lsb()  : LSB position of a tap slice inside the packed column
package line_tap_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_MAX_LINE   = 2048;
  localparam int unsigned DEFAULT_NUM_TAPS   = 3;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (value > 0) ? value - 1 : 0;
    while (x != 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Bit offset of tap slice 'tap' for pixels of 'width' bits.
  function automatic int unsigned tap_lsb(input int unsigned tap, input int unsigned width);
    return tap * width;
  endfunction

endpackage

// File: rtl/sdpram_sync.sv
// Single-clock simple dual-port RAM, registered read, no output register.
//   clk                       : clock
//   wr_en / wr_addr / wr_data : write port
//   rd_en / rd_addr / rd_data : read port; rd_data holds while rd_en is low
module sdpram_sync #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage array carries no reset; callers mask data that was never written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/line_tap_buffer.sv
// Multi-line video buffer: for every accepted pixel presents a vertical
// column of NUM_TAPS pixels at the same x, one cycle later.
//   clk, rst_n   : clock, asynchronous active-low reset
//   frame_start  : frame restart pulse; latches h_active (clamped to 2..MAX_LINE)
//   h_active     : pixels per line
//   in_valid     : pixel strobe, in_data : pixel
//   out_valid    : column valid (1 cycle after in_valid)
//   out_taps     : slice 0 = current line, slice k = k lines above
//   out_col      : column index of out_taps
//   out_rows_ok  : every slice holds real frame data
//   out_eol      : last column of the line
module line_tap_buffer
  import line_tap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned MAX_LINE   = DEFAULT_MAX_LINE,
  parameter int unsigned ADDR_WIDTH = clog2(MAX_LINE),
  parameter int unsigned NUM_TAPS   = DEFAULT_NUM_TAPS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_start,
  input  logic [ADDR_WIDTH:0]            h_active,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           out_valid,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] out_taps,
  output logic [ADDR_WIDTH-1:0]          out_col,
  output logic                           out_rows_ok,
  output logic                           out_eol
);

  localparam int unsigned LEN_W    = ADDR_WIDTH + 1;
  localparam int unsigned ROW_W    = clog2(NUM_TAPS);
  localparam int unsigned NUM_RAMS = NUM_TAPS - 1;

  logic [LEN_W-1:0]      h_len;
  logic [LEN_W-1:0]      h_clamp_c;
  logic [LEN_W-1:0]      len_c;
  logic [ADDR_WIDTH-1:0] col;
  logic [ADDR_WIDTH-1:0] col_c;
  logic [ROW_W-1:0]      row_cnt;
  logic [ROW_W-1:0]      row_c;
  logic                  eol_c;

  logic [DATA_WIDTH-1:0] s1_data;
  logic [ROW_W-1:0]      s1_row;
  logic [NUM_RAMS-1:0][DATA_WIDTH-1:0] rd_data;

  // Clamp the requested line length into the legal range.
  always_comb begin
    h_clamp_c = h_active;
    if (h_active < LEN_W'(2)) begin
      h_clamp_c = LEN_W'(2);
    end else if (h_active > LEN_W'(MAX_LINE)) begin
      h_clamp_c = LEN_W'(MAX_LINE);
    end
  end

  // A pixel arriving with frame_start is column 0 / row 0 of the new frame.
  assign len_c = frame_start ? h_clamp_c : h_len;
  assign col_c = frame_start ? '0 : col;
  assign row_c = frame_start ? '0 : row_cnt;
  assign eol_c = ({1'b0, col_c} == (len_c - LEN_W'(1)));

  // Line length latch, column and row counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_len   <= LEN_W'(MAX_LINE);
      col     <= '0;
      row_cnt <= '0;
    end else begin
      if (frame_start) h_len <= h_clamp_c;
      if (in_valid) begin
        if (eol_c) begin
          col     <= '0;
          row_cnt <= (row_c == ROW_W'(NUM_TAPS - 1)) ? row_c : row_c + ROW_W'(1);
        end else begin
          col     <= col_c + ADDR_WIDTH'(1);
          row_cnt <= row_c;
        end
      end else if (frame_start) begin
        col     <= '0;
        row_cnt <= '0;
      end
    end
  end

  // Stage 0 -> stage 1 registers; flags hold during input gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      s1_data     <= '0;
      s1_row      <= '0;
      out_col     <= '0;
      out_eol     <= 1'b0;
      out_rows_ok <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s1_data     <= in_data;
        s1_row      <= row_c;
        out_col     <= col_c;
        out_eol     <= eol_c;
        out_rows_ok <= (row_c == ROW_W'(NUM_TAPS - 1));
      end
    end
  end

  // RAM cascade: RAM0 takes the current pixel, RAM k takes RAM k-1's old word.
  for (genvar k = 0; k < NUM_RAMS; k++) begin : g_ram
    logic [DATA_WIDTH-1:0] wr_data_c;
    if (k == 0) begin : g_head
      assign wr_data_c = s1_data;
    end else begin : g_link
      assign wr_data_c = rd_data[k-1];
    end

    sdpram_sync #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MAX_LINE),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .clk     (clk),
      .wr_en   (out_valid),
      .wr_addr (out_col),
      .wr_data (wr_data_c),
      .rd_en   (in_valid),
      .rd_addr (col_c),
      .rd_data (rd_data[k])
    );
  end

  // Tap column; upper slices read as zero until the frame has that many rows.
  assign out_taps[tap_lsb(0, DATA_WIDTH) +: DATA_WIDTH] = s1_data;
  for (genvar k = 1; k < NUM_TAPS; k++) begin : g_tap
    assign out_taps[tap_lsb(k, DATA_WIDTH) +: DATA_WIDTH] =
      (s1_row >= ROW_W'(k)) ? rd_data[k-1] : '0;
  end

endmodule

// File: tb/tb_line_tap_buffer.sv
module tb_line_tap_buffer;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 11;
  localparam int unsigned NT  = 3;
  localparam int unsigned DW5 = 24;
  localparam int unsigned AW5 = 11;
  localparam int unsigned NT5 = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic              frame_start, in_valid;
  logic [AW:0]       h_active;
  logic [DW-1:0]     in_data;
  logic              out_valid, out_rows_ok, out_eol;
  logic [NT*DW-1:0]  out_taps;
  logic [AW-1:0]     out_col;

  logic              frame_start5, in_valid5;
  logic [AW5:0]      h_active5;
  logic [DW5-1:0]    in_data5;
  logic              out_valid5, out_rows_ok5, out_eol5;
  logic [NT5*DW5-1:0] out_taps5;
  logic [AW5-1:0]    out_col5;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  line_tap_buffer dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .h_active(h_active),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_taps(out_taps),
    .out_col(out_col), .out_rows_ok(out_rows_ok), .out_eol(out_eol)
  );

  line_tap_buffer #(.DATA_WIDTH(DW5), .MAX_LINE(1920), .ADDR_WIDTH(AW5), .NUM_TAPS(NT5)) dut5 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start5), .h_active(h_active5),
    .in_valid(in_valid5), .in_data(in_data5), .out_valid(out_valid5), .out_taps(out_taps5),
    .out_col(out_col5), .out_rows_ok(out_rows_ok5), .out_eol(out_eol5)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic v, input logic [DW-1:0] d, input logic fs, input logic [AW:0] ha);
    in_valid = v; in_data = d; frame_start = fs; h_active = ha;
    @(posedge clk); #1;
    in_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic step5(input logic v, input logic [DW5-1:0] d, input logic fs, input logic [AW5:0] ha);
    in_valid5 = v; in_data5 = d; frame_start5 = fs; h_active5 = ha;
    @(posedge clk); #1;
    in_valid5 = 1'b0; frame_start5 = 1'b0;
  endtask

  task automatic do_reset();
    frame_start = 0; in_valid = 0; in_data = '0; h_active = '0;
    frame_start5 = 0; in_valid5 = 0; in_data5 = '0; h_active5 = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Back-to-back / gapped stream with 4-pixel lines, pixel value = index.
  function automatic logic [NT*DW-1:0] exp_fill(input int p);
    logic [DW-1:0] s0, s1, s2;
    s0 = DW'(p);
    s1 = (p >= 4) ? DW'(p - 4) : '0;
    s2 = (p >= 8) ? DW'(p - 8) : '0;
    return {s2, s1, s0};
  endfunction

  task automatic test_reset();
    frame_start = 0; in_valid = 0; in_data = '0; h_active = '0;
    frame_start5 = 0; in_valid5 = 0; in_data5 = '0; h_active5 = '0;
    #2 rst_n = 1'b0;
    #2;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    tests_run++; if (out_taps !== '0) begin tests_failed++; $display("FAIL reset_taps: got %h expected 0", out_taps); end
    tests_run++; if (out_col !== '0) begin tests_failed++; $display("FAIL reset_col: got %0d expected 0", out_col); end
    tests_run++; if (out_rows_ok !== 1'b0) begin tests_failed++; $display("FAIL reset_rows_ok: got %b expected 0", out_rows_ok); end
    tests_run++; if (out_eol !== 1'b0) begin tests_failed++; $display("FAIL reset_eol: got %b expected 0", out_eol); end
    tests_run++; if (out_taps5 !== '0) begin tests_failed++; $display("FAIL reset_taps5: got %h expected 0", out_taps5); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_fill();
    do_reset();
    step(1'b0, '0, 1'b1, 12'd4);
    for (int p = 0; p < 12; p++) begin
      step(1'b1, DW'(p), 1'b0, '0);
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL fill_valid p=%0d: got %b expected 1", p, out_valid); end
      tests_run++; if (out_taps !== exp_fill(p)) begin tests_failed++; $display("FAIL fill_taps p=%0d: got %h expected %h", p, out_taps, exp_fill(p)); end
      tests_run++; if (out_col !== AW'(p % 4)) begin tests_failed++; $display("FAIL fill_col p=%0d: got %0d expected %0d", p, out_col, p % 4); end
      tests_run++; if (out_eol !== ((p % 4) == 3)) begin tests_failed++; $display("FAIL fill_eol p=%0d: got %b expected %b", p, out_eol, (p % 4) == 3); end
      tests_run++; if (out_rows_ok !== (p >= 8)) begin tests_failed++; $display("FAIL fill_rows_ok p=%0d: got %b expected %b", p, out_rows_ok, p >= 8); end
      if (p == 2) begin
        tests_run++; if (out_taps !== 24'h000002) begin tests_failed++; $display("FAIL fill_l0c2: got %h expected 000002", out_taps); end
      end
      if (p == 9) begin
        tests_run++; if (out_taps !== 24'h010509) begin tests_failed++; $display("FAIL fill_l2c1: got %h expected 010509", out_taps); end
      end
    end
    step(1'b0, '0, 1'b0, '0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL fill_tail_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_gapped();
    do_reset();
    step(1'b0, '0, 1'b1, 12'd4);
    for (int p = 0; p < 12; p++) begin
      step(1'b1, DW'(p), 1'b0, '0);
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL gap_valid p=%0d: got %b expected 1", p, out_valid); end
      tests_run++; if (out_taps !== exp_fill(p)) begin tests_failed++; $display("FAIL gap_taps p=%0d: got %h expected %h", p, out_taps, exp_fill(p)); end
      step(1'b0, '0, 1'b0, '0);
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL gap_idle p=%0d: got %b expected 0", p, out_valid); end
      step(1'b0, '0, 1'b0, '0);
    end
  endtask

  task automatic test_frame_restart();
    do_reset();
    step(1'b0, '0, 1'b1, 12'd4);
    for (int p = 0; p < 6; p++) step(1'b1, DW'(p), 1'b0, '0);
    step(1'b0, '0, 1'b1, 12'd6);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL restart_idle: got %b expected 0", out_valid); end
    step(1'b1, 8'hA0, 1'b0, '0);
    tests_run++; if (out_col !== '0) begin tests_failed++; $display("FAIL restart_col: got %0d expected 0", out_col); end
    tests_run++; if (out_rows_ok !== 1'b0) begin tests_failed++; $display("FAIL restart_rows_ok: got %b expected 0", out_rows_ok); end
    tests_run++; if (out_taps !== 24'h0000A0) begin tests_failed++; $display("FAIL restart_taps: got %h expected 0000a0", out_taps); end
    for (int c = 1; c < 6; c++) begin
      step(1'b1, DW'(8'hA0 + c), 1'b0, '0);
      tests_run++; if (out_eol !== (c == 5)) begin tests_failed++; $display("FAIL restart_eol c=%0d: got %b expected %b", c, out_eol, c == 5); end
    end
    step(1'b1, 8'hA6, 1'b0, '0);
    tests_run++; if (out_col !== '0) begin tests_failed++; $display("FAIL restart_wrap_col: got %0d expected 0", out_col); end
    tests_run++; if (out_taps !== 24'h00A0A6) begin tests_failed++; $display("FAIL restart_line1: got %h expected 00a0a6", out_taps); end
    // frame_start together with a pixel: that pixel is column 0 with the new length
    step(1'b1, 8'hB0, 1'b1, 12'd3);
    tests_run++; if (out_col !== '0) begin tests_failed++; $display("FAIL fs_same_col: got %0d expected 0", out_col); end
    tests_run++; if (out_taps !== 24'h0000B0) begin tests_failed++; $display("FAIL fs_same_taps: got %h expected 0000b0", out_taps); end
    step(1'b1, 8'hB1, 1'b0, '0);
    step(1'b1, 8'hB2, 1'b0, '0);
    tests_run++; if (out_eol !== 1'b1) begin tests_failed++; $display("FAIL fs_same_eol: got %b expected 1", out_eol); end
    step(1'b1, 8'hB3, 1'b0, '0);
    tests_run++; if (out_taps !== 24'h00B0B3) begin tests_failed++; $display("FAIL fs_same_line1: got %h expected 00b0b3", out_taps); end
  endtask

  task automatic test_clamp();
    int eol_count;
    do_reset();
    step(1'b0, '0, 1'b1, 12'd1);
    step(1'b1, 8'h10, 1'b0, '0);
    step(1'b1, 8'h11, 1'b0, '0);
    tests_run++; if (out_eol !== 1'b1 || out_col !== AW'(1)) begin tests_failed++; $display("FAIL clamp_min_eol: got eol=%b col=%0d expected eol=1 col=1", out_eol, out_col); end
    step(1'b1, 8'h12, 1'b0, '0);
    tests_run++; if (out_col !== '0) begin tests_failed++; $display("FAIL clamp_min_wrap: got %0d expected 0", out_col); end
    tests_run++; if (out_taps !== 24'h001012) begin tests_failed++; $display("FAIL clamp_min_taps: got %h expected 001012", out_taps); end
    step(1'b0, '0, 1'b1, 12'd4000);
    eol_count = 0;
    for (int i = 0; i < 2049; i++) begin
      step(1'b1, DW'(i), 1'b0, '0);
      if (out_eol === 1'b1) eol_count++;
      if (i == 2047) begin
        tests_run++; if (out_eol !== 1'b1 || out_col !== AW'(2047)) begin tests_failed++; $display("FAIL clamp_max_eol: got eol=%b col=%0d expected eol=1 col=2047", out_eol, out_col); end
      end
      if (i == 2048) begin
        tests_run++; if (out_col !== '0) begin tests_failed++; $display("FAIL clamp_max_wrap: got %0d expected 0", out_col); end
      end
    end
    tests_run++; if (eol_count != 1) begin tests_failed++; $display("FAIL clamp_max_eol_count: got %0d expected 1", eol_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b0, '0, 1'b1, 12'd4);
    for (int p = 0; p < 12; p++) step(1'b1, DW'(p), 1'b0, '0);
    tests_run++; if (out_eol !== 1'b1 || out_rows_ok !== 1'b1) begin tests_failed++; $display("FAIL areset_pre: got eol=%b rows_ok=%b expected 1 1", out_eol, out_rows_ok); end
    #3 rst_n = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_valid: got %b expected 0", out_valid); end
    tests_run++; if (out_taps !== '0) begin tests_failed++; $display("FAIL areset_taps: got %h expected 0", out_taps); end
    tests_run++; if (out_col !== '0) begin tests_failed++; $display("FAIL areset_col: got %0d expected 0", out_col); end
    tests_run++; if (out_rows_ok !== 1'b0) begin tests_failed++; $display("FAIL areset_rows_ok: got %b expected 0", out_rows_ok); end
    tests_run++; if (out_eol !== 1'b0) begin tests_failed++; $display("FAIL areset_eol: got %b expected 0", out_eol); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 8'h55, 1'b0, '0);
    tests_run++; if (out_col !== '0) begin tests_failed++; $display("FAIL areset_next_col: got %0d expected 0", out_col); end
    tests_run++; if (out_taps !== 24'h000055 || out_rows_ok !== 1'b0) begin tests_failed++; $display("FAIL areset_next_taps: got %h rows_ok=%b expected 000055 0", out_taps, out_rows_ok); end
  endtask

  task automatic test_param_sweep();
    logic [DW5-1:0] img [6][7];
    logic [NT5*DW5-1:0] exp;
    do_reset();
    step5(1'b0, '0, 1'b1, 12'd7);
    for (int ln = 0; ln < 6; ln++) begin
      for (int c = 0; c < 7; c++) begin
        img[ln][c] = DW5'($urandom);
        step5(1'b1, img[ln][c], 1'b0, '0);
        exp = '0;
        for (int k = 0; k < int'(NT5); k++) if (ln >= k) exp[k*DW5 +: DW5] = img[ln-k][c];
        tests_run++; if (out_taps5 !== exp) begin tests_failed++; $display("FAIL sweep_taps l=%0d c=%0d: got %h expected %h", ln, c, out_taps5, exp); end
        tests_run++; if (out_col5 !== AW5'(c) || out_eol5 !== (c == 6) || out_rows_ok5 !== (ln >= 4)) begin
          tests_failed++;
          $display("FAIL sweep_flags l=%0d c=%0d: got col=%0d eol=%b ok=%b expected col=%0d eol=%b ok=%b",
                   ln, c, out_col5, out_eol5, out_rows_ok5, c, c == 6, ln >= 4);
        end
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          step5(1'b0, '0, 1'b0, '0);
          tests_run++; if (out_valid5 !== 1'b0) begin tests_failed++; $display("FAIL sweep_gap l=%0d c=%0d: got %b expected 0", ln, c, out_valid5); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_gapped();
    test_frame_restart();
    test_clamp();
    test_async_reset();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
